// File: rtl/exe_mem_pipeline_pkg.sv
// exe_mem_pipeline_pkg: flag bit indices, default wait limit and the memory/writeback control vector layout
package exe_mem_pipeline_pkg;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int MAX_WAIT_DEF = 15;
  typedef struct packed {
    logic mem_rd;
    logic mem_wr;
    logic reg_wr;
  } ctrl_t;
  localparam ctrl_t CTRL_NONE = '0;
endpackage

// File: rtl/exe_mem_pipeline_mem_wait_timer.sv
// mem_wait_timer: saturating count of consecutive stall edges with a sticky timeout flag
// Ports: clk_i, rst_ni (async active-low), stall_i (MEM waiting), capture_i (stage advances), timeout_o (sticky)
module mem_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stall_i,
  input  logic capture_i,
  output logic timeout_o
);
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  always_comb begin
    cnt_d = capture_i ? '0 : (stall_i && cnt_q != LIMIT) ? cnt_q + 1'b1 : cnt_q;
    timeout_d = timeout_q | (stall_i & (cnt_d == LIMIT));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
endmodule

// File: rtl/exe_mem_pipeline.sv
// exe_mem_pipeline: EXE/MEM pipeline register with NZCV flag register, memory-wait stall, flush-to-bubble and wait timeout
// Ports: Clk, Reset_n (async active-low); EXE_* instruction slot in; Flush, Mem_Ready;
//        MEM_* registered slot out; Flags_Q architectural NZCV; Stall_Out (combinational); Mem_Timeout (sticky)
module exe_mem_pipeline
  import exe_mem_pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int WAIT_W = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] EXE_Result,
  input  logic [DATA_W-1:0] EXE_B,
  input  logic [3:0]        EXE_Rd_num,
  input  logic [4:0]        EXE_Opcode,
  input  logic [3:0]        EXE_Flags,
  input  logic              EXE_S,
  input  logic              EXE_Valid,
  input  logic              EXE_Mem_Rd,
  input  logic              EXE_Mem_Wr,
  input  logic              EXE_Reg_Wr,
  input  logic              Flush,
  input  logic              Mem_Ready,
  output logic [DATA_W-1:0] MEM_Result,
  output logic [DATA_W-1:0] MEM_Store_Data,
  output logic [3:0]        MEM_Rd_num,
  output logic [4:0]        MEM_Opcode,
  output logic              MEM_Mem_Rd,
  output logic              MEM_Mem_Wr,
  output logic              MEM_Reg_Wr,
  output logic              MEM_Valid,
  output logic [3:0]        Flags_Q,
  output logic              Stall_Out,
  output logic              Mem_Timeout
);
  ctrl_t ctrl_q, ctrl_d, ctrl_in;
  logic valid_q, valid_d, flush_pend_q, flush_pend_d, kill, take;
  logic [DATA_W-1:0] result_q, result_d, store_q, store_d;
  logic [3:0] rd_q, rd_d, flags_q, flags_d;
  logic [4:0] op_q, op_d;
  assign ctrl_in = {EXE_Mem_Rd, EXE_Mem_Wr, EXE_Reg_Wr};
  assign Stall_Out = valid_q & (ctrl_q.mem_rd | ctrl_q.mem_wr) & ~Mem_Ready;
  always_comb begin
    kill = Flush | flush_pend_q | ~EXE_Valid;
    take = ~Stall_Out & ~kill;
    valid_d = Stall_Out ? valid_q : ~kill;
    ctrl_d = Stall_Out ? ctrl_q : kill ? CTRL_NONE : ctrl_in;
    result_d = take ? EXE_Result : result_q;
    store_d = take ? EXE_B : store_q;
    rd_d = take ? EXE_Rd_num : rd_q;
    op_d = take ? EXE_Opcode : op_q;
    flags_d = (take & EXE_S) ? EXE_Flags : flags_q;
    // a flush seen while stalled is remembered so the slot still dies on the next capture
    flush_pend_d = Stall_Out & (flush_pend_q | Flush);
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ctrl_q <= CTRL_NONE;
      valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      result_q <= '0;
      store_q <= '0;
      rd_q <= '0;
      op_q <= '0;
      flags_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      valid_q <= valid_d;
      flush_pend_q <= flush_pend_d;
      result_q <= result_d;
      store_q <= store_d;
      rd_q <= rd_d;
      op_q <= op_d;
      flags_q <= flags_d;
    end
  end
  mem_wait_timer #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_timer (
    .clk_i(Clk),
    .rst_ni(Reset_n),
    .stall_i(Stall_Out),
    .capture_i(~Stall_Out),
    .timeout_o(Mem_Timeout)
  );
  assign MEM_Result = result_q;
  assign MEM_Store_Data = store_q;
  assign MEM_Rd_num = rd_q;
  assign MEM_Opcode = op_q;
  assign MEM_Mem_Rd = ctrl_q.mem_rd;
  assign MEM_Mem_Wr = ctrl_q.mem_wr;
  assign MEM_Reg_Wr = ctrl_q.reg_wr;
  assign MEM_Valid = valid_q;
  assign Flags_Q = flags_q;
endmodule

// File: tb/tb_exe_mem_pipeline.sv
// tb_exe_mem_pipeline: scoreboard bench for the EXE/MEM pipeline register
module tb_exe_mem_pipeline;
  localparam int MAXW = 15;
  logic Clk = 1'b0, Reset_n = 1'b0;
  logic [31:0] EXE_Result = '0, EXE_B = '0;
  logic [3:0] EXE_Rd_num = '0, EXE_Flags = '0;
  logic [4:0] EXE_Opcode = '0;
  logic EXE_S = 0, EXE_Valid = 0, EXE_Mem_Rd = 0, EXE_Mem_Wr = 0, EXE_Reg_Wr = 0, Flush = 0, Mem_Ready = 1;
  logic [31:0] MEM_Result, MEM_Store_Data;
  logic [3:0] MEM_Rd_num, Flags_Q;
  logic [4:0] MEM_Opcode;
  logic MEM_Mem_Rd, MEM_Mem_Wr, MEM_Reg_Wr, MEM_Valid, Stall_Out, Mem_Timeout;
  typedef struct {
    logic valid, rd, wr, rw, pend, to;
    logic [31:0] res, b;
    logic [3:0] rdn, flags;
    logic [4:0] op;
    int cnt;
  } st_t;
  st_t m;
  st_t sb[$];
  int total = 0, bad = 0;
  exe_mem_pipeline dut (
    .Clk(Clk), .Reset_n(Reset_n), .EXE_Result(EXE_Result), .EXE_B(EXE_B), .EXE_Rd_num(EXE_Rd_num),
    .EXE_Opcode(EXE_Opcode), .EXE_Flags(EXE_Flags), .EXE_S(EXE_S), .EXE_Valid(EXE_Valid),
    .EXE_Mem_Rd(EXE_Mem_Rd), .EXE_Mem_Wr(EXE_Mem_Wr), .EXE_Reg_Wr(EXE_Reg_Wr), .Flush(Flush),
    .Mem_Ready(Mem_Ready), .MEM_Result(MEM_Result), .MEM_Store_Data(MEM_Store_Data),
    .MEM_Rd_num(MEM_Rd_num), .MEM_Opcode(MEM_Opcode), .MEM_Mem_Rd(MEM_Mem_Rd), .MEM_Mem_Wr(MEM_Mem_Wr),
    .MEM_Reg_Wr(MEM_Reg_Wr), .MEM_Valid(MEM_Valid), .Flags_Q(Flags_Q), .Stall_Out(Stall_Out),
    .Mem_Timeout(Mem_Timeout)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic reset_model();
    m = '{valid: 0, rd: 0, wr: 0, rw: 0, pend: 0, to: 0, res: 0, b: 0, rdn: 0, flags: 0, op: 0, cnt: 0};
  endtask
  task automatic compare_all(input st_t e);
    chk("valid", 32'(MEM_Valid), 32'(e.valid));
    chk("mem_rd", 32'(MEM_Mem_Rd), 32'(e.rd));
    chk("mem_wr", 32'(MEM_Mem_Wr), 32'(e.wr));
    chk("reg_wr", 32'(MEM_Reg_Wr), 32'(e.rw));
    chk("result", MEM_Result, e.res);
    chk("store", MEM_Store_Data, e.b);
    chk("rd_num", 32'(MEM_Rd_num), 32'(e.rdn));
    chk("opcode", 32'(MEM_Opcode), 32'(e.op));
    chk("flags", 32'(Flags_Q), 32'(e.flags));
    chk("timeout", 32'(Mem_Timeout), 32'(e.to));
  endtask
  task automatic ins(input logic v, input logic [31:0] res, input logic [31:0] b, input logic [3:0] rdn,
                     input logic [4:0] op, input logic rd, input logic wr, input logic rw, input logic s,
                     input logic [3:0] fl);
    EXE_Valid = v; EXE_Result = res; EXE_B = b; EXE_Rd_num = rdn; EXE_Opcode = op;
    EXE_Mem_Rd = rd; EXE_Mem_Wr = wr; EXE_Reg_Wr = rw; EXE_S = s; EXE_Flags = fl;
  endtask
  task automatic cycle();
    st_t e;
    logic stall;
    #1;
    stall = m.valid & (m.rd | m.wr) & ~Mem_Ready;
    chk("stall_out", 32'(Stall_Out), 32'(stall));
    if (stall) begin
      m.pend = m.pend | Flush;
      if (m.cnt != MAXW) m.cnt++;
      if (m.cnt == MAXW) m.to = 1;
    end else begin
      if (Flush | m.pend | ~EXE_Valid) begin
        m.valid = 0; m.rd = 0; m.wr = 0; m.rw = 0;
      end else begin
        m.valid = 1; m.rd = EXE_Mem_Rd; m.wr = EXE_Mem_Wr; m.rw = EXE_Reg_Wr;
        m.res = EXE_Result; m.b = EXE_B; m.rdn = EXE_Rd_num; m.op = EXE_Opcode;
        if (EXE_S) m.flags = EXE_Flags;
      end
      m.pend = 0;
      m.cnt = 0;
    end
    sb.push_back(m);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      compare_all(e);
    end
  endtask
  initial begin
    reset_model();
    #12;
    compare_all(m);
    chk("stall_rst", 32'(Stall_Out), 32'd0);
    Reset_n = 1;
    // ALU op with flag update
    ins(1, 32'h0000_1234, 32'h0, 4'd5, 5'd1, 0, 0, 1, 1, 4'b0100);
    cycle();
    chk("first_res", MEM_Result, 32'h1234);
    chk("first_flags", 32'(Flags_Q), 32'b0100);
    // load waiting three cycles while an S instruction waits upstream
    ins(1, 32'h100, 32'h0, 4'd2, 5'd2, 1, 0, 1, 0, 4'b0);
    cycle();
    Mem_Ready = 0;
    ins(1, 32'h55, 32'h0, 4'd3, 5'd3, 0, 0, 1, 1, 4'b1111);
    repeat (3) cycle();
    Mem_Ready = 1;
    cycle();
    chk("late_flags", 32'(Flags_Q), 32'b1111);
    // flush during stall becomes a bubble on the next capture
    ins(1, 32'h200, 32'h0, 4'd4, 5'd2, 1, 0, 1, 0, 4'b0);
    cycle();
    Mem_Ready = 0;
    ins(1, 32'h77, 32'h0, 4'd6, 5'd4, 0, 0, 1, 1, 4'b0011);
    Flush = 1;
    cycle();
    Flush = 0;
    cycle();
    Mem_Ready = 1;
    cycle();
    chk("bubble_valid", 32'(MEM_Valid), 32'd0);
    cycle();
    chk("after_bubble", 32'(Flags_Q), 32'b0011);
    // store timing out
    ins(1, 32'h300, 32'hDEAD_BEEF, 4'd0, 5'd5, 0, 1, 0, 0, 4'b0);
    cycle();
    Mem_Ready = 0;
    repeat (14) cycle();
    chk("to_before", 32'(Mem_Timeout), 32'd0);
    repeat (3) cycle();
    Mem_Ready = 1;
    cycle();
    chk("to_sticky", 32'(Mem_Timeout), 32'd1);
    // invalid slot with S set leaves flags alone
    ins(0, 32'h999, 32'h0, 4'd7, 5'd6, 0, 0, 1, 1, 4'b1010);
    cycle();
    // random traffic
    for (int i = 0; i < 60; i++) begin
      ins($urandom_range(0, 3) != 0, $urandom, $urandom, 4'($urandom), 5'($urandom),
          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), 4'($urandom));
      Flush = $urandom_range(0, 5) == 0;
      Mem_Ready = $urandom_range(0, 2) != 0;
      cycle();
    end
    Flush = 0;
    // asynchronous reset in the middle of a stall
    Mem_Ready = 1;
    ins(1, 32'h400, 32'h0, 4'd8, 5'd2, 1, 0, 1, 0, 4'b0);
    cycle();
    Mem_Ready = 0;
    ins(0, 32'h0, 32'h0, 4'd0, 5'd0, 0, 0, 0, 0, 4'b0);
    repeat (2) cycle();
    chk("stall_pre_rst", 32'(Stall_Out), 32'd1);
    #2 Reset_n = 0;
    #1 reset_model();
    compare_all(m);
    chk("stall_mid_rst", 32'(Stall_Out), 32'd0);
    #1 Reset_n = 1;
    Mem_Ready = 1;
    ins(1, 32'hABCD, 32'h1, 4'd9, 5'd7, 0, 0, 1, 1, 4'b1001);
    repeat (2) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
